// File: rtl/goboard_info_pkg.sv
// Shared geometry, control codes and state type for the goboard info-text panel.
package goboard_info_pkg;

  localparam int INFO_COLS   = 16;
  localparam int INFO_ROWS   = 32;
  localparam int INFO_ADDR_W = 9;
  localparam int INFO_COL_W  = $clog2(INFO_COLS);
  localparam int INFO_ROW_W  = $clog2(INFO_ROWS);

  localparam logic [7:0] CHR_SPACE = 8'h20;
  localparam logic [7:0] CHR_CR    = 8'h0D;
  localparam logic [7:0] CHR_LF    = 8'h0A;
  localparam logic [7:0] CHR_BS    = 8'h08;
  localparam logic [7:0] CHR_FF    = 8'h0C;

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } info_state_e;

endpackage

// File: rtl/goboard_info_writer_if.sv
// Byte-stream input and info-RAM write port of the goboard info writer.
interface goboard_info_writer_if;
  import goboard_info_pkg::*;

  logic                   in_valid;
  logic [7:0]             in_char;
  logic                   in_ready;
  logic                   wea;
  logic [7:0]             ascii;
  logic [INFO_ADDR_W-1:0] write_ram_addr;
  logic                   busy;
  logic [INFO_COL_W-1:0]  cursor_col;
  logic [INFO_ROW_W-1:0]  cursor_row;

  modport master (
    output in_valid, in_char,
    input  in_ready, wea, ascii, write_ram_addr, busy, cursor_col, cursor_row
  );

  modport slave (
    input  in_valid, in_char,
    output in_ready, wea, ascii, write_ram_addr, busy, cursor_col, cursor_row
  );

endinterface

// File: rtl/goboard_info_writer.sv
// Byte stream -> info-text RAM writes with cursor; one registered write the cycle after acceptance.
// in_ready only in IDLE (1 char/cycle); held off for the whole 512-cycle space-fill sweep.
module goboard_info_writer
  import goboard_info_pkg::*;
#(
  parameter int COLS         = INFO_COLS,
  parameter int ROWS         = INFO_ROWS,
  parameter int ADDR_W       = INFO_ADDR_W,
  parameter bit CLEAR_ON_RST = 1'b1
) (
  input  logic                  sys_clk_in,
  input  logic                  arst_n_i,
  goboard_info_writer_if.slave  info
);

  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);

  info_state_e       state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              clr_last_q, clr_last_d;
  logic              wea_q, wea_d;
  logic [7:0]        ascii_q, ascii_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              busy_q, busy_d;

  logic              dec_write;
  logic              dec_clear;
  logic [7:0]        dec_char;
  logic [ADDR_W-1:0] dec_addr;
  logic [COL_W-1:0]  dec_col;
  logic [ROW_W-1:0]  dec_row;

  // Character decode against the cursor as it stands at acceptance.
  always_comb begin
    dec_write = 1'b0;
    dec_clear = 1'b0;
    dec_char  = info.in_char;
    dec_addr  = {row_q, col_q};
    dec_col   = col_q;
    dec_row   = row_q;
    case (info.in_char) inside
      [8'h20:8'h7E]: begin
        dec_write = 1'b1;
        dec_col   = col_q + 1'b1;
        if (&col_q) dec_row = row_q + 1'b1;
      end
      CHR_CR: dec_col = '0;
      CHR_LF: begin
        dec_col = '0;
        dec_row = row_q + 1'b1;
      end
      CHR_BS: begin
        if (col_q != '0) begin
          dec_write = 1'b1;
          dec_char  = CHR_SPACE;
          dec_col   = col_q - 1'b1;
          dec_addr  = {row_q, col_q - 1'b1};
        end
      end
      CHR_FF: begin
        dec_clear = 1'b1;
        dec_col   = '0;
        dec_row   = '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    clr_cnt_d  = clr_cnt_q;
    clr_last_d = clr_last_q;
    wea_d      = 1'b0;
    ascii_d    = ascii_q;
    addr_d     = addr_q;
    busy_d     = busy_q;
    case (state_q)
      ST_CLEAR: begin
        // Leave only after the last address has actually been presented on the port.
        if (clr_last_q) begin
          state_d    = ST_IDLE;
          busy_d     = 1'b0;
          clr_last_d = 1'b0;
          clr_cnt_d  = '0;
        end else begin
          wea_d      = 1'b1;
          ascii_d    = CHR_SPACE;
          addr_d     = clr_cnt_q;
          clr_cnt_d  = clr_cnt_q + 1'b1;
          clr_last_d = &clr_cnt_q;
        end
      end
      ST_IDLE: begin
        if (info.in_valid) begin
          col_d = dec_col;
          row_d = dec_row;
          wea_d = dec_write;
          if (dec_write) begin
            ascii_d = dec_char;
            addr_d  = dec_addr;
          end
          if (dec_clear) begin
            state_d = ST_CLEAR;
            busy_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_in or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q    <= CLEAR_ON_RST ? ST_CLEAR : ST_IDLE;
      busy_q     <= CLEAR_ON_RST;
      col_q      <= '0;
      row_q      <= '0;
      clr_cnt_q  <= '0;
      clr_last_q <= 1'b0;
      wea_q      <= 1'b0;
      ascii_q    <= CHR_SPACE;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      col_q      <= col_d;
      row_q      <= row_d;
      clr_cnt_q  <= clr_cnt_d;
      clr_last_q <= clr_last_d;
      wea_q      <= wea_d;
      ascii_q    <= ascii_d;
      addr_q     <= addr_d;
    end
  end

  assign info.in_ready       = (state_q == ST_IDLE);
  assign info.wea            = wea_q;
  assign info.ascii          = ascii_q;
  assign info.write_ram_addr = addr_q;
  assign info.busy           = busy_q;
  assign info.cursor_col     = col_q;
  assign info.cursor_row     = row_q;

endmodule

// File: tb/tb_goboard_info_writer.sv
// Bench for goboard_info_writer: random byte stream vs. a cursor/panel model, writes scored from a queue.
module tb_goboard_info_writer;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  goboard_info_writer_if ifc();

  goboard_info_writer #(.CLEAR_ON_RST(1'b1)) dut (
    .sys_clk_in (clk),
    .arst_n_i   (arst_n),
    .info       (ifc)
  );

  typedef struct {
    int addr;
    int data;
    bit clr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_row   = 0;
  int   m_col   = 0;

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, req, req, $time);
    end
  endtask

  task automatic push_clear();
    for (int a = 0; a < 512; a++) exp_q.push_back('{a, 32'h20, 1'b1});
  endtask

  // Panel model: 16x32 text grid, cursor wraps to the next row, row 31 wraps to 0.
  task automatic model_accept(input int b, output bit wr, output int waddr, output int wdata);
    wr = 1'b0; waddr = 0; wdata = 0;
    if (b >= 32 && b <= 126) begin
      wr = 1'b1; waddr = m_row * 16 + m_col; wdata = b;
      m_col++;
      if (m_col == 16) begin m_col = 0; m_row = (m_row + 1) % 32; end
    end else if (b == 13) begin
      m_col = 0;
    end else if (b == 10) begin
      m_col = 0; m_row = (m_row + 1) % 32;
    end else if (b == 8) begin
      if (m_col > 0) begin m_col--; wr = 1'b1; waddr = m_row * 16 + m_col; wdata = 32; end
    end else if (b == 12) begin
      m_row = 0; m_col = 0;
    end
    if (wr) exp_q.push_back('{waddr, wdata, 1'b0});
    if (b == 12) push_clear();
  endtask

  task automatic send(input int b);
    int cnt = 0;
    bit wr;
    int wa, wd;
    ifc.in_valid = 1'b1;
    ifc.in_char  = b[7:0];
    while (!ifc.in_ready && cnt < 2000) begin @(negedge clk); cnt++; end
    if (cnt >= 2000) begin
      check("handshake_timeout", ifc.in_ready, 1);
      ifc.in_valid = 1'b0;
      return;
    end
    model_accept(b, wr, wa, wd);
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    check("wea_latency", ifc.wea, wr);
    if (wr) begin
      check("addr_latency", ifc.write_ram_addr, wa);
      check("ascii_latency", ifc.ascii, wd);
    end
    check("cursor_col", ifc.cursor_col, m_col);
    check("cursor_row", ifc.cursor_row, m_row);
    if (b == 12) begin
      check("ff_in_ready", ifc.in_ready, 0);
      check("ff_busy", ifc.busy, 1);
    end
  endtask

  task automatic wait_idle();
    int cnt = 0;
    while (!ifc.in_ready && cnt < 2000) begin @(posedge clk); #1; cnt++; end
    check("idle_reached", ifc.in_ready, 1);
    check("idle_busy", ifc.busy, 0);
    check("sweep_drained", exp_q.size(), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_wea"},   ifc.wea, 0);
    check({tag, "_ascii"}, ifc.ascii, 32);
    check({tag, "_addr"},  ifc.write_ram_addr, 0);
    check({tag, "_col"},   ifc.cursor_col, 0);
    check({tag, "_row"},   ifc.cursor_row, 0);
    check({tag, "_busy"},  ifc.busy, 1);
    check({tag, "_ready"}, ifc.in_ready, 0);
  endtask

  // Monitor: every write on the RAM port must match the head of the expected queue.
  always @(negedge clk) begin
    if (arst_n && ifc.wea) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_wea: addr %0d ascii 0x%0h with nothing expected", ifc.write_ram_addr, ifc.ascii);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", ifc.write_ram_addr, mon_e.addr);
        check("wr_ascii", ifc.ascii, mon_e.data);
        if (mon_e.clr) begin
          check("clr_busy", ifc.busy, 1);
          check("clr_in_ready", ifc.in_ready, 0);
        end else begin
          check("wr_busy", ifc.busy, 0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int r, b, n_ff;
    ifc.in_valid = 1'b0;
    ifc.in_char  = 8'h00;
    push_clear();
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    arst_n = 1'b1;
    wait_idle();

    // "GO" back to back
    send(8'h47);
    send(8'h4F);

    // end-of-row wrap at (3,15) and at (31,15)
    send(8'h0D); send(8'h0A); send(8'h0A); send(8'h0A);
    repeat (15) send(8'h78);
    send(8'h41);
    repeat (27) send(8'h0A);
    repeat (15) send(8'h79);
    send(8'h41);

    // BS / CR / BS at col 0 / LF at row 31
    send(8'h0A); send(8'h0A);
    repeat (5) send(8'h7A);
    send(8'h08);
    send(8'h0D);
    send(8'h08);
    repeat (29) send(8'h0A);
    send(8'h0A);

    // FF with in_valid kept high into the sweep
    send(8'h61); send(8'h62);
    send(8'h0C);
    send(8'h51);

    // randomized stream
    n_ff = 0;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70)       b = $urandom_range(32, 126);
      else if (r < 76)  b = 13;
      else if (r < 82)  b = 10;
      else if (r < 90)  b = 8;
      else if (r < 91 && n_ff < 2) begin b = 12; n_ff++; end
      else begin
        do b = $urandom_range(0, 255);
        while ((b >= 32 && b <= 126) || b == 8 || b == 10 || b == 12 || b == 13);
      end
      send(b);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    end

    // async reset in the middle of a sweep
    send(8'h0C);
    cnt = 0;
    while (!(ifc.wea && ifc.write_ram_addr == 9'd200) && cnt < 1000) begin @(negedge clk); cnt++; end
    check("reach_addr200", ifc.write_ram_addr, 200);
    #1 arst_n = 1'b0;
    #1 check_reset_vals("midrst");
    exp_q.delete();
    m_row = 0; m_col = 0;
    push_clear();
    repeat (3) @(negedge clk);
    check_reset_vals("midrst_hold");
    arst_n = 1'b1;
    wait_idle();
    send(8'h01);
    send(8'h80);

    repeat (5) @(negedge clk);
    check("final_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
